// File: rtl/plic_irq_gateway.sv
// PLIC interrupt gateway: synchronises raw sources and turns level/edge requests into one pending bit per line.
// Latency SYNC_STAGES+1 cycles source->pending; a line is held off between claim and complete.
module plic_irq_gateway #(
  parameter int unsigned               NUM_SOURCES    = 32,
  parameter int unsigned               SYNC_STAGES    = 2,
  parameter logic [NUM_SOURCES-1:0]    EDGE_MASK      = '0,
  parameter int unsigned               EDGE_CNT_WIDTH = 2,
  localparam int unsigned              IDW            = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  input  logic                   claim_valid_i,
  input  logic [IDW-1:0]         claim_id_i,
  input  logic                   complete_valid_i,
  input  logic [IDW-1:0]         complete_id_i,
  output logic [NUM_SOURCES-1:0] pending_o,
  output logic [NUM_SOURCES-1:0] in_service_o,
  output logic [NUM_SOURCES-1:0] edge_overflow_o
);

  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_SOURCES-1:0]    w_sync;
  logic [NUM_SOURCES-1:0]    r_prev;
  logic [NUM_SOURCES-1:0]    r_pend;
  logic [NUM_SOURCES-1:0]    r_serv;
  logic [NUM_SOURCES-1:0]    r_ovf;
  logic [EDGE_CNT_WIDTH-1:0] r_cnt [NUM_SOURCES];

  logic [NUM_SOURCES-1:0]    w_claim;
  logic [NUM_SOURCES-1:0]    w_done;
  logic [NUM_SOURCES-1:0]    w_rise;
  logic [NUM_SOURCES-1:0]    w_pend_nx;
  logic [NUM_SOURCES-1:0]    w_serv_nx;
  logic [NUM_SOURCES-1:0]    w_ovf_nx;
  logic [EDGE_CNT_WIDTH-1:0] w_cnt_nx [NUM_SOURCES];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = irq_src_i;
    end else begin : g_sync
      logic [NUM_SOURCES-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
          for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
          r_sync[0] <= irq_src_i;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_claim[i]   = claim_valid_i && (claim_id_i == IDW'(i)) && r_pend[i];
      w_done[i]    = complete_valid_i && (complete_id_i == IDW'(i)) && r_serv[i];
      w_rise[i]    = w_sync[i] & ~r_prev[i];
      w_pend_nx[i] = r_pend[i];
      w_serv_nx[i] = r_serv[i];
      w_ovf_nx[i]  = r_ovf[i];
      w_cnt_nx[i]  = r_cnt[i];
      if (EDGE_MASK[i]) begin
        if (w_claim[i]) begin
          w_pend_nx[i] = 1'b0;
          w_serv_nx[i] = 1'b1;
        end else if (w_done[i]) begin
          w_serv_nx[i] = 1'b0;
          // A coincident edge replaces the queued one, so the count is left as is.
          if (w_rise[i]) begin
            w_pend_nx[i] = 1'b1;
          end else if (r_cnt[i] != '0) begin
            w_pend_nx[i] = 1'b1;
            w_cnt_nx[i]  = r_cnt[i] - 1'b1;
          end
        end else if (!r_pend[i] && !r_serv[i] && w_rise[i]) begin
          w_pend_nx[i] = 1'b1;
        end
        if (w_rise[i] && (r_pend[i] || r_serv[i]) && !w_done[i]) begin
          if (r_cnt[i] == CNT_MAX) w_ovf_nx[i] = 1'b1;
          else                     w_cnt_nx[i] = r_cnt[i] + 1'b1;
        end
      end else begin
        if (w_claim[i]) begin
          w_pend_nx[i] = 1'b0;
          w_serv_nx[i] = 1'b1;
        end else if (w_done[i]) begin
          w_serv_nx[i] = 1'b0;
        end else if (!r_pend[i] && !r_serv[i] && w_sync[i]) begin
          w_pend_nx[i] = 1'b1;
        end
      end
      if (i == 0) begin
        w_pend_nx[i] = 1'b0;
        w_serv_nx[i] = 1'b0;
        w_ovf_nx[i]  = 1'b0;
        w_cnt_nx[i]  = '0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      r_prev <= '0;
      r_pend <= '0;
      r_serv <= '0;
      r_ovf  <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) r_cnt[i] <= '0;
    end else begin
      r_prev <= w_sync;
      r_pend <= w_pend_nx;
      r_serv <= w_serv_nx;
      r_ovf  <= w_ovf_nx;
      r_cnt  <= w_cnt_nx;
    end
  end

  assign pending_o       = r_pend;
  assign in_service_o    = r_serv;
  assign edge_overflow_o = r_ovf;

endmodule
